// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: decodes the held instruction register
// and sequences IF/ID/EX/MEM/WB, driving datapath selects and enables.
module mc_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [3:0]  aluc,
  output logic [1:0]  alu_a_sel,
  output logic [1:0]  alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  rf_wdst,
  output logic [1:0]  rf_wsel,
  output logic [2:0]  state,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t cur, nxt;

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_instr;

  logic       d_legal;
  logic       d_rtype;
  logic       d_j;
  logic       d_jal;
  logic       d_jr;
  logic       d_beq;
  logic       d_bne;
  logic       d_lw;
  logic       d_sw;
  logic       d_ovf;
  logic [3:0] d_aluc;
  logic [1:0] d_asel;
  logic [1:0] d_bsel;

  assign op           = instr[31:26];
  assign fn           = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign state        = cur;

  // Instruction decode: purely a function of the held IR contents
  always_comb begin
    d_legal = 1'b0;
    d_rtype = 1'b0;
    d_j     = 1'b0;
    d_jal   = 1'b0;
    d_jr    = 1'b0;
    d_beq   = 1'b0;
    d_bne   = 1'b0;
    d_lw    = 1'b0;
    d_sw    = 1'b0;
    d_ovf   = 1'b0;
    d_aluc  = 4'b0000;
    d_asel  = 2'b00;
    d_bsel  = 2'b00;
    case (op)
      6'h00: begin
        d_legal = 1'b1;
        d_rtype = 1'b1;
        case (fn)
          6'h00: begin d_aluc = 4'b1110; d_asel = 2'b01; end
          6'h02: begin d_aluc = 4'b1101; d_asel = 2'b01; end
          6'h03: begin d_aluc = 4'b1100; d_asel = 2'b01; end
          6'h04: d_aluc = 4'b1110;
          6'h06: d_aluc = 4'b1101;
          6'h07: d_aluc = 4'b1100;
          6'h08: begin d_jr = 1'b1; d_rtype = 1'b0; end
          6'h20: begin d_aluc = 4'b0010; d_ovf = 1'b1; end
          6'h21: d_aluc = 4'b0000;
          6'h22: begin d_aluc = 4'b0011; d_ovf = 1'b1; end
          6'h23: d_aluc = 4'b0001;
          6'h24: d_aluc = 4'b0100;
          6'h25: d_aluc = 4'b0101;
          6'h26: d_aluc = 4'b0110;
          6'h27: d_aluc = 4'b0111;
          6'h2A: d_aluc = 4'b1011;
          6'h2B: d_aluc = 4'b1010;
          default: begin d_legal = 1'b0; d_rtype = 1'b0; end
        endcase
      end
      6'h02: begin d_legal = 1'b1; d_j = 1'b1; end
      6'h03: begin d_legal = 1'b1; d_jal = 1'b1; end
      6'h04: begin d_legal = 1'b1; d_beq = 1'b1; d_aluc = 4'b0001; end
      6'h05: begin d_legal = 1'b1; d_bne = 1'b1; d_aluc = 4'b0001; end
      6'h08: begin d_legal = 1'b1; d_aluc = 4'b0010; d_bsel = 2'b01; d_ovf = 1'b1; end
      6'h09: begin d_legal = 1'b1; d_aluc = 4'b0000; d_bsel = 2'b01; end
      6'h0A: begin d_legal = 1'b1; d_aluc = 4'b1011; d_bsel = 2'b01; end
      6'h0B: begin d_legal = 1'b1; d_aluc = 4'b1010; d_bsel = 2'b01; end
      6'h0C: begin d_legal = 1'b1; d_aluc = 4'b0100; d_bsel = 2'b10; end
      6'h0D: begin d_legal = 1'b1; d_aluc = 4'b0101; d_bsel = 2'b10; end
      6'h0E: begin d_legal = 1'b1; d_aluc = 4'b0110; d_bsel = 2'b10; end
      6'h0F: begin d_legal = 1'b1; d_aluc = 4'b1000; d_bsel = 2'b10; end
      6'h23: begin d_legal = 1'b1; d_lw = 1'b1; d_bsel = 2'b01; end
      6'h2B: begin d_legal = 1'b1; d_sw = 1'b1; d_bsel = 2'b01; end
      default: d_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IF;
    else     cur <= nxt;
  end

  // Next state and datapath controls
  always_comb begin
    nxt          = cur;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    ir_we        = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    aluc         = 4'b0000;
    alu_a_sel    = 2'b00;
    alu_b_sel    = 2'b00;
    rf_we        = 1'b0;
    rf_wdst      = 2'b00;
    rf_wsel      = 2'b00;
    illegal      = 1'b0;

    // ALU controls stay stable from EX until the instruction retires
    if (cur == S_EX || cur == S_MEM || cur == S_WB) begin
      aluc      = d_aluc;
      alu_a_sel = d_asel;
      alu_b_sel = d_bsel;
    end

    case (cur)
      S_IF: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_we   = mem_ready;
        if (mem_ready) nxt = S_ID;
      end
      S_ID: begin
        if (!d_legal) begin
          illegal = 1'b1;
          nxt     = S_IF;
        end else if (d_j || d_jal) begin
          pc_we  = 1'b1;
          pc_sel = 2'b10;
          if (d_jal) begin
            rf_we   = 1'b1;
            rf_wdst = 2'b10;
            rf_wsel = 2'b10;
          end
          nxt = S_IF;
        end else if (d_jr) begin
          pc_we  = 1'b1;
          pc_sel = 2'b11;
          nxt    = S_IF;
        end else begin
          nxt = S_EX;
        end
      end
      S_EX: begin
        if (d_beq || d_bne) begin
          pc_we  = (d_beq & alu_zero) | (d_bne & ~alu_zero);
          pc_sel = 2'b01;
          nxt    = S_IF;
        end else if (d_lw || d_sw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = d_sw;
        if (mem_ready) nxt = d_sw ? S_IF : S_WB;
      end
      S_WB: begin
        rf_we   = ~(d_ovf & alu_overflow);
        rf_wdst = d_rtype ? 2'b00 : 2'b01;
        rf_wsel = d_lw ? 2'b01 : 2'b00;
        nxt     = S_IF;
      end
      default: nxt = S_IF;
    endcase

    // Reset silences every side effect in the cycle it is asserted
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      rf_we   = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table walked through several
// instruction sequences, plus instruction latency measurements.
module tb_mc_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready;
  logic        alu_zero;
  logic        alu_overflow;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        ir_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [3:0]  aluc;
  logic [1:0]  alu_a_sel;
  logic [1:0]  alu_b_sel;
  logic        rf_we;
  logic [1:0]  rf_wdst;
  logic [1:0]  rf_wsel;
  logic [2:0]  state;
  logic        illegal;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .pc_we(pc_we), .pc_sel(pc_sel), .ir_we(ir_we), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .aluc(aluc),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .rf_wdst(rf_wdst), .rf_wsel(rf_wsel), .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pc_we,pc_sel,ir_we,mem_req,mem_we,mem_addr_sel,aluc,a_sel,b_sel,rf_we,rf_wdst,rf_wsel,illegal
  logic [20:0] act_o;
  assign act_o = {pc_we, pc_sel, ir_we, mem_req, mem_we, mem_addr_sel, aluc,
                  alu_a_sel, alu_b_sel, rf_we, rf_wdst, rf_wsel, illegal};

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        mr;
    logic        az;
    logic        ao;
    logic [2:0]  st;
    logic [20:0] o;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] ADD  = 32'h00221820;
  localparam logic [31:0] LW   = 32'h8C220004;
  localparam logic [31:0] SW   = 32'hAC220004;
  localparam logic [31:0] BEQ  = 32'h10220003;
  localparam logic [31:0] BNE  = 32'h14220003;
  localparam logic [31:0] J    = 32'h08000010;
  localparam logic [31:0] JAL  = 32'h0C000010;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] ILL  = 32'hFC000000;
  localparam logic [31:0] SLL  = 32'h00021900;
  localparam logic [31:0] ORI  = 32'h342200FF;

  function automatic logic [20:0] ob(
    input logic pcwe, input logic [1:0] pcsel, input logic irwe,
    input logic mreq, input logic mwe, input logic mas, input logic [3:0] ac,
    input logic [1:0] as, input logic [1:0] bs, input logic rfwe,
    input logic [1:0] wd, input logic [1:0] ws, input logic ill);
    return {pcwe, pcsel, irwe, mreq, mwe, mas, ac, as, bs, rfwe, wd, ws, ill};
  endfunction

  task automatic v(input logic r, input logic [31:0] ins, input logic mr,
                   input logic az, input logic ao, input logic [2:0] st,
                   input logic [20:0] o);
    vec_t e;
    e.rst = r; e.instr = ins; e.mr = mr; e.az = az; e.ao = ao;
    e.st = st; e.o = o;
    tbl.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic measure(input string name, input logic [31:0] ins,
                         input int lat);
    int n;
    @(negedge clk);
    rst = 1'b0; instr = ins; mem_ready = 1'b1; alu_zero = 1'b0; alu_overflow = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (state != 3'd0 && n < 20);
    check(name, n, lat);
  endtask

  logic [20:0] z, fetch, fwait;

  initial begin
    rst = 1'b1; instr = ADDU; mem_ready = 1'b1; alu_zero = 1'b0; alu_overflow = 1'b0;
    z     = '0;
    fetch = ob(1, 2'b00, 1, 1, 0, 0, 4'h0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
    fwait = ob(0, 2'b00, 0, 1, 0, 0, 4'h0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);

    // reset, then addu
    v(1, ADDU, 1, 0, 0, 3'd0, z);
    v(1, ADDU, 1, 0, 0, 3'd0, z);
    v(0, ADDU, 1, 0, 0, 3'd0, fetch);
    v(0, ADDU, 1, 0, 0, 3'd1, z);
    v(0, ADDU, 1, 0, 0, 3'd2, z);
    v(0, ADDU, 1, 0, 1, 3'd4, ob(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 2'b00, 2'b00, 0));
    // add with overflow suppresses the write
    v(0, ADD, 0, 0, 0, 3'd0, fwait);
    v(0, ADD, 1, 0, 0, 3'd0, fetch);
    v(0, ADD, 1, 0, 0, 3'd1, z);
    v(0, ADD, 1, 0, 0, 3'd2, ob(0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 0, 0, 0));
    v(0, ADD, 1, 0, 1, 3'd4, ob(0, 0, 0, 0, 0, 0, 4'b0010, 0, 0, 0, 2'b00, 0, 0));
    // lw with three wait cycles in MEM
    v(0, LW, 1, 0, 0, 3'd0, fetch);
    v(0, LW, 1, 0, 0, 3'd1, z);
    v(0, LW, 1, 0, 0, 3'd2, ob(0, 0, 0, 0, 0, 0, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, LW, 0, 0, 0, 3'd3, ob(0, 0, 0, 1, 0, 1, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, LW, 0, 0, 0, 3'd3, ob(0, 0, 0, 1, 0, 1, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, LW, 0, 0, 0, 3'd3, ob(0, 0, 0, 1, 0, 1, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, LW, 1, 0, 0, 3'd3, ob(0, 0, 0, 1, 0, 1, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, LW, 1, 0, 0, 3'd4, ob(0, 0, 0, 0, 0, 0, 4'h0, 0, 2'b01, 1, 2'b01, 2'b01, 0));
    // beq taken then not taken
    v(0, BEQ, 1, 0, 0, 3'd0, fetch);
    v(0, BEQ, 1, 0, 0, 3'd1, z);
    v(0, BEQ, 1, 1, 0, 3'd2, ob(1, 2'b01, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    v(0, BEQ, 1, 0, 0, 3'd0, fetch);
    v(0, BEQ, 1, 0, 0, 3'd1, z);
    v(0, BEQ, 1, 0, 0, 3'd2, ob(0, 2'b01, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    // jumps
    v(0, J, 1, 0, 0, 3'd0, fetch);
    v(0, J, 1, 0, 0, 3'd1, ob(1, 2'b10, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    v(0, JAL, 1, 0, 0, 3'd0, fetch);
    v(0, JAL, 1, 0, 0, 3'd1, ob(1, 2'b10, 0, 0, 0, 0, 4'h0, 0, 0, 1, 2'b10, 2'b10, 0));
    v(0, JR, 1, 0, 0, 3'd0, fetch);
    v(0, JR, 1, 0, 0, 3'd1, ob(1, 2'b11, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    // unsupported opcode: one-cycle pulse, back to IF
    v(0, ILL, 1, 0, 0, 3'd0, fetch);
    v(0, ILL, 1, 0, 0, 3'd1, ob(0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1));
    v(0, ILL, 0, 0, 0, 3'd0, fwait);
    // sll: shamt on port a
    v(0, SLL, 1, 0, 0, 3'd0, fetch);
    v(0, SLL, 1, 0, 0, 3'd1, z);
    v(0, SLL, 1, 0, 0, 3'd2, ob(0, 0, 0, 0, 0, 0, 4'b1110, 2'b01, 2'b00, 0, 0, 0, 0));
    v(0, SLL, 1, 0, 0, 3'd4, ob(0, 0, 0, 0, 0, 0, 4'b1110, 2'b01, 2'b00, 1, 2'b00, 2'b00, 0));
    // ori: zero-extended immediate, rt destination
    v(0, ORI, 1, 0, 0, 3'd0, fetch);
    v(0, ORI, 1, 0, 0, 3'd1, z);
    v(0, ORI, 1, 0, 0, 3'd2, ob(0, 0, 0, 0, 0, 0, 4'b0101, 0, 2'b10, 0, 0, 0, 0));
    v(0, ORI, 1, 0, 0, 3'd4, ob(0, 0, 0, 0, 0, 0, 4'b0101, 0, 2'b10, 1, 2'b01, 2'b00, 0));
    // sw interrupted by reset mid-MEM with mem_ready pending
    v(0, SW, 1, 0, 0, 3'd0, fetch);
    v(0, SW, 1, 0, 0, 3'd1, z);
    v(0, SW, 1, 0, 0, 3'd2, ob(0, 0, 0, 0, 0, 0, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(1, SW, 1, 0, 0, 3'd3, ob(0, 0, 0, 0, 0, 1, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, SW, 1, 0, 0, 3'd0, fetch);
    // complete sw
    v(0, SW, 1, 0, 0, 3'd1, z);
    v(0, SW, 1, 0, 0, 3'd2, ob(0, 0, 0, 0, 0, 0, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, SW, 1, 0, 0, 3'd3, ob(0, 0, 0, 1, 1, 1, 4'h0, 0, 2'b01, 0, 0, 0, 0));
    v(0, SW, 0, 0, 0, 3'd0, fwait);
    // bne taken on zero flag clear
    v(0, BNE, 1, 0, 0, 3'd0, fetch);
    v(0, BNE, 1, 0, 0, 3'd1, z);
    v(0, BNE, 1, 0, 0, 3'd2, ob(1, 2'b01, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0, 0, 0));
    v(0, BNE, 0, 0, 0, 3'd0, fwait);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; instr = tbl[i].instr; mem_ready = tbl[i].mr;
      alu_zero = tbl[i].az; alu_overflow = tbl[i].ao;
      #1;
      check($sformatf("row%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
      check($sformatf("row%0d_outs", i), {11'd0, act_o}, {11'd0, tbl[i].o});
    end

    // latency with mem_ready held high, starting from IF
    measure("lat_j", J, 2);
    measure("lat_jal", JAL, 2);
    measure("lat_jr", JR, 2);
    measure("lat_beq", BEQ, 3);
    measure("lat_addu", ADDU, 4);
    measure("lat_sw", SW, 4);
    measure("lat_lw", LW, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 The block SHALL have a single clock, clk; reset is synchronous and active-high, named rst.
REQ-002 The port list SHALL be as follows, one signal per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  IR contents; stable from ID to end of instruction
- mem_ready  in  1  memory completes the access this cycle
- alu_zero  in  1  ALU zero flag
- alu_overflow  in  1  ALU overflow flag
- pc_we  out  1  PC write enable
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target, 11 = rs
- ir_we  out  1  IR write enable
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr_sel  out  1  0 = PC, 1 = ALU result
- aluc  out  4  ALU operation code
- alu_a_sel  out  2  00 = rs, 01 = zero-extended shamt
- alu_b_sel  out  2  00 = rt, 01 = sign-extended imm, 10 = zero-extended imm
- rf_we  out  1  register-file write enable
- rf_wdst  out  2  00 = rd, 01 = rt, 10 = r31
- rf_wsel  out  2  00 = ALU, 01 = memory data, 10 = PC
- state  out  3  current state
- illegal  out  1  unsupported instruction pulse

Function
REQ-003 States and encodings SHALL be IF = 0, ID = 1, EX = 2, MEM = 3, WB = 4; the state register is updated on the rising edge of clk.
REQ-004 Outputs SHALL be combinational from state, instr, mem_ready and the ALU flags; any output not stated for a state SHALL be 0.
REQ-005 IF: mem_req = 1 and mem_addr_sel = 0.
- ir_we = pc_we = mem_ready, with pc_sel = 00.
- Stay in IF while mem_ready = 0; go to ID when it is 1.
REQ-006 ID, j: pc_we = 1, pc_sel = 10, go to IF.
REQ-007 ID, jal: as j, plus rf_we = 1, rf_wdst = 10, rf_wsel = 10 (the PC already holds PC+4).
REQ-008 ID, jr: pc_we = 1, pc_sel = 11, go to IF.
REQ-009 ID, unsupported opcode or funct: illegal = 1 for that cycle, no write enables, go to IF.
REQ-010 ID, all other instructions: go to EX.
REQ-011 aluc SHALL be driven in EX and held unchanged through MEM and WB of the same instruction; it SHALL be 0000 in IF and ID. The mapping is:
- addu, addiu, lw, sw: 0000
- add, addi: 0010
- subu, beq, bne: 0001
- sub: 0011
- and, andi: 0100
- or, ori: 0101
- xor, xori: 0110
- nor: 0111
- lui: 1000
- slt, slti: 1011
- sltu, sltiu: 1010
- sra, srav: 1100
- sll, sllv: 1110
- srl, srlv: 1101
REQ-012 Operand selects SHALL be:
- sll/srl/sra: a = shamt, b = rt.
- Variable shifts: a = rs, b = rt.
- R-type arithmetic/logic: a = rs, b = rt.
- addi, addiu, slti, sltiu, lw, sw: b = sign-extended imm.
- andi, ori, xori, lui: b = zero-extended imm.
REQ-013 EX, beq/bne: pc_we = (beq & alu_zero) | (bne & ~alu_zero), pc_sel = 01, go to IF.
REQ-014 EX, lw/sw: go to MEM.
REQ-015 EX, other instructions: go to WB.
REQ-016 MEM: mem_req = 1, mem_addr_sel = 1, mem_we = sw.
- Stay in MEM while mem_ready = 0.
- On mem_ready = 1: sw goes to IF, lw goes to WB.
REQ-017 WB: rf_we = 1, except rf_we = 0 when the instruction is add, sub or addi and alu_overflow = 1.
- R-type: rf_wdst = 00.
- I-type and lw: rf_wdst = 01.
- lw: rf_wsel = 01; all others: rf_wsel = 00.
- Go to IF.
REQ-018 Latency with mem_ready held at 1 SHALL be:
- j, jal, jr: 2 cycles
- beq, bne: 3 cycles
- ALU instructions and sw: 4 cycles
- lw: 5 cycles
REQ-019 mem_req SHALL stay asserted, with address select unchanged, until mem_ready is sampled 1.

Reset
REQ-020 While rst = 1, state SHALL be forced to IF on the next edge.
REQ-021 While rst = 1, pc_we, ir_we, mem_req, mem_we, rf_we and illegal SHALL be 0 in that same cycle, whatever the state.
REQ-022 rst SHALL take priority over all transitions, including mid-MEM with a pending mem_ready.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- rst = 1 for 2 cycles, mem_ready = 1 -> state = 0, all enables 0; first cycle after release: ir_we = pc_we = 1.
- instr = 0x00221821 (addu $3,$1,$2) -> states IF, ID, EX, WB; aluc = 0000 in EX and WB; rf_we = 1, rf_wdst = 00 in WB only; IF again at cycle 5.
- lw with mem_ready = 0 for 3 MEM cycles -> mem_req high 4 MEM cycles, mem_addr_sel = 1, then WB with rf_wsel = 01, rf_wdst = 01.
- beq in EX -> aluc = 0001, pc_sel = 01; alu_zero = 1 gives pc_we = 1; alu_zero = 0 gives pc_we = 0; next state IF.
- add (funct 0x20) with alu_overflow = 1 in WB -> rf_we = 0; addu with alu_overflow = 1 -> rf_we = 1.
- opcode 0x3F -> illegal = 1 for exactly one ID cycle, then IF; rst asserted during MEM of sw -> mem_we = 0 that cycle, state IF next.
